spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 8, bits per word (legal range 4..32).
REQ-002 Parameter DIV_W, default 8, width of the runtime clock-divider input.
REQ-003 Port clk  input  1  system clock; every register updates on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-low; clock clk.
REQ-005 Port start  input  1  transfer request; sampled only when busy=0.
REQ-006 Port tx_data  input  DATA_W  word to send, MSB first, latched on accept.
REQ-007 Port cpol  input  1  SCLK idle level, latched on accept from IDLE.
REQ-008 Port cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge; latched with cpol.
REQ-009 Port div  input  DIV_W  SCLK half-period in clk cycles, latched on accept; value 0 is treated as 1.
REQ-010 Port hold_cs  input  1  keep cs_n low after this word for a multi-word frame; latched on accept.
REQ-011 Port busy  output  1  high from the cycle after accept until the done cycle, inclusive.
REQ-012 Port done  output  1  one-cycle pulse; rx_data is valid in the same cycle.
REQ-013 Port rx_data  output  DATA_W  last received word, held until the next done.
REQ-014 Ports sclk, mosi, cs_n  output  1 each; miso  input  1  SPI bus signals.

Function
REQ-015 The FSM SHALL have states IDLE, LEAD, XFER, TRAIL and HOLD.
REQ-016 IDLE: cs_n=1 and sclk=latched cpol; start=1 SHALL cause an accept and a move to LEAD.
REQ-017 LEAD: cs_n=0, mosi=tx MSB, wait one half-period, then go to XFER.
REQ-018 XFER: SHALL generate exactly 2*DATA_W SCLK edges, each one half-period apart, with the first edge leading (toggling away from cpol).
REQ-019 cpha=0: miso sampled on leading edges; mosi shifts to the next bit on trailing edges.
REQ-020 cpha=1: mosi shifts on leading edges (first bit appears on the first leading edge); miso sampled on trailing edges.
REQ-021 After the final edge, sclk=cpol; TRAIL SHALL wait one half-period, then pulse done and load rx_data.
REQ-022 On done: with hold_cs latched, go to HOLD and keep cs_n=0; otherwise go to IDLE and set cs_n=1.
REQ-023 HOLD: busy=0; start=1 SHALL accept a new word with the same cpol/cpha and go directly to XFER (no LEAD); hold_cs is re-latched.
REQ-024 HOLD with start=0 and hold_cs=0 SHALL release: cs_n=1, go to IDLE.
REQ-025 Latency from IDLE: done asserts exactly Dv*(2*DATA_W+2)+1 cycles after the accept cycle, where Dv = max(div,1).
REQ-026 start while busy=1 SHALL be ignored; tx_data, cpol, cpha, div and hold_cs changes while busy SHALL have no effect.
REQ-027 The half-period counter SHALL be DIV_W bits wide and reload on every SCLK edge; it has no wrap-around effect.

Reset
REQ-028 reset=0 at a clk edge SHALL force the following: IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, latched cpol/cpha/hold_cs=0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no done pulse; cs_n SHALL be high from the next edge.

Structure
REQ-030 Shared package spi_pkg SHALL hold the FSM state type and the SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
REQ-031 One sub-module, spi_clkgen, SHALL generate the half-period tick from the latched div value; the shift registers and FSM stay in spi_master.

Verification
REQ-032 Mode 0, DATA_W=8, div=4, tx_data=0xA5, mosi looped to miso -> rx_data=0xA5, done at cycle 73 after accept, 16 sclk edges.
REQ-033 Mode 3, div=2, tx_data=0x3C, slave model drives 0xC3 -> rx_data=0xC3, sclk idles high, mosi bits match 0x3C MSB first.
REQ-034 start pulsed again mid-XFER with tx_data=0xFF -> ignored; single done; mosi carries only the original word.
REQ-035 hold_cs=1 words 0x12, 0x34, then hold_cs=0 -> cs_n low throughout both words, high after the second done, no LEAD before the second word.
REQ-036 reset=0 at edge 5 of XFER -> cs_n=1 and busy=0 next cycle, no done, rx_data=0.
REQ-037 div=0 -> timing identical to div=1 (done 19 cycles after accept for DATA_W=8).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding and the four SPI modes.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_XFER,
        ST_TRAIL,
        ST_HOLD
    } state_t;

    // Modes packed as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator: one tick every max(div,1) clk cycles while enabled.
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] last_cnt;

    // A divider of 0 behaves like 1, so the terminal count never underflows.
    assign last_cnt = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick     = en && (cnt_reg == last_cnt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (!en || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, all four modes, runtime divider, optional chip-select hold for multi-word frames.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  div,
    input  logic              hold_cs,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    input  logic              miso
);

    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    state_t state_reg, state_next;

    logic              cpol_reg, cpha_reg, hold_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [DATA_W-1:0] tx_sh_reg, rx_sh_reg, rx_data_reg;
    logic [EDGE_W-1:0] edge_cnt_reg;
    logic              sclk_reg, sclk_next;
    logic              cs_n_reg, cs_n_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic accept, tick, run, leading, last_edge, do_sample, do_shift;

    assign accept    = start && !busy_reg && (state_reg == ST_IDLE || state_reg == ST_HOLD);
    assign run       = (state_reg == ST_LEAD) || (state_reg == ST_XFER) || (state_reg == ST_TRAIL);
    assign leading   = ~edge_cnt_reg[0];
    assign last_edge = (edge_cnt_reg == LAST_EDGE);
    assign do_sample = leading ^ cpha_reg;
    // With cpha=1 the MSB is already on mosi, so the first leading edge only "presents" it.
    assign do_shift  = cpha_reg ? (leading && (edge_cnt_reg != '0)) : !leading;

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .div   (div_reg),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_LEAD;
            ST_LEAD:  if (tick) state_next = ST_XFER;
            ST_XFER:  if (tick && last_edge) state_next = ST_TRAIL;
            ST_TRAIL: if (tick) state_next = hold_reg ? ST_HOLD : ST_IDLE;
            ST_HOLD: begin
                if (accept) begin
                    state_next = ST_XFER;
                end else if (!busy_reg && !hold_cs) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n_next = (state_next == ST_IDLE);
        done_next = (state_reg == ST_TRAIL) && tick;
        busy_next = accept || (busy_reg && !done_reg);
        sclk_next = sclk_reg;
        if (state_reg == ST_IDLE) begin
            sclk_next = accept ? cpol : cpol_reg;
        end else if (state_reg == ST_XFER && tick) begin
            sclk_next = ~sclk_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            hold_reg     <= 1'b0;
            div_reg      <= '0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_data_reg  <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            sclk_reg <= sclk_next;
            cs_n_reg <= cs_n_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
            if (accept) begin
                tx_sh_reg    <= tx_data;
                hold_reg     <= hold_cs;
                div_reg      <= div;
                edge_cnt_reg <= '0;
                if (state_reg == ST_IDLE) begin
                    cpol_reg <= cpol;
                    cpha_reg <= cpha;
                end
            end else if (state_reg == ST_XFER && tick) begin
                edge_cnt_reg <= edge_cnt_reg + 1'b1;
                if (do_sample) begin
                    rx_sh_reg <= {rx_sh_reg[DATA_W-2:0], miso};
                end
                if (do_shift) begin
                    tx_sh_reg <= {tx_sh_reg[DATA_W-2:0], 1'b0};
                end
            end
            if (done_next) begin
                rx_data_reg <= rx_sh_reg;
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rx_data = rx_data_reg;
    assign sclk    = sclk_reg;
    assign mosi    = tx_sh_reg[DATA_W-1];
    assign cs_n    = cs_n_reg;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed vector table, corner sequences and random words vs. a slave model.
module tb_spi_master
    import spi_pkg::*;
;

    logic       clk, reset, start, cpol, cpha, hold_cs;
    logic [7:0] tx_data, div, rx_data;
    logic       busy, done, sclk, mosi, cs_n, miso;

    spi_master #(.DATA_W(8), .DIV_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .cpol    (cpol),
        .cpha    (cpha),
        .div     (div),
        .hold_cs (hold_cs),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs_n    (cs_n),
        .miso    (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Slave model: tracks SCLK edges while selected, captures mosi on the
    // mode's sampling edge and drives its own word on the opposite edge.
    logic       loop_en, miso_q, mode_cpha;
    logic [7:0] slave_word;
    int         edge_total;
    bit         mosi_q[$];

    assign miso = loop_en ? mosi : miso_q;

    initial begin
        int  sl_edges, e;
        logic sclk_prev, cs_prev, lead;
        miso_q = 1'b0; edge_total = 0; sl_edges = 0; sclk_prev = 1'b0; cs_prev = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (cs_n) begin
                sl_edges = 0;
            end else if (cs_prev) begin
                miso_q = slave_word[7];
            end else if (sclk !== sclk_prev) begin
                e = sl_edges;
                sl_edges++;
                edge_total++;
                lead = (e % 2 == 0);
                if (lead != mode_cpha) mosi_q.push_back(mosi);
                if (!mode_cpha && !lead) miso_q = slave_word[7 - (((e + 1) / 2) % 8)];
                if (mode_cpha && lead) miso_q = slave_word[7 - ((e / 2) % 8)];
            end
            sclk_prev = sclk;
            cs_prev   = cs_n;
        end
    end

    typedef struct {
        int         lat;
        logic [7:0] rx;
        int         edges;
        logic [7:0] mw;
        int         cs_hi;
        logic       cs_at_start;
        logic       cs_at_done;
        logic       cs_after;
        logic       sclk_after;
    } res_t;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sl;
        logic [1:0] mode;
        logic [7:0] dv;
        logic       lp;
        int         exp_lat;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input logic [1:0] mode,
                        input logic [7:0] dv, input logic hold, input logic lp, input bit poke,
                        output res_t r);
        int e0, q0;
        bit fin;
        @(negedge clk);
        r.cs_at_start = cs_n;
        slave_word = sl; loop_en = lp; mode_cpha = mode[0];
        start = 1'b1; tx_data = tx; cpol = mode[1]; cpha = mode[0]; div = dv; hold_cs = hold;
        e0 = edge_total; q0 = mosi_q.size();
        @(posedge clk); #1;
        start = 1'b0; tx_data = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); div = 8'($urandom);
        r.lat = 0; r.cs_hi = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            r.lat++;
            if (r.lat == 1) check("busy_after_accept", busy, 1);
            if (poke && r.lat == 30) begin start = 1'b1; tx_data = 8'hFF; end
            if (poke && r.lat == 31) start = 1'b0;
            if (done) begin
                fin = 1;
            end else begin
                if (cs_n) r.cs_hi++;
                if (r.lat >= 4000) begin check("done_timeout", done, 1); fin = 1; end
            end
        end
        r.rx = rx_data; r.cs_at_done = cs_n; r.edges = edge_total - e0;
        r.mw = '0;
        for (int i = 0; i < 8; i++)
            r.mw = {r.mw[6:0], (q0 + i < mosi_q.size()) ? mosi_q[q0 + i] : 1'b0};
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        r.cs_after = cs_n; r.sclk_after = sclk;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        res_t       r, r2;
        logic [7:0] t_r, s_r, dv_r, exp_rx;
        logic [1:0] m_r;
        logic       lp_r;
        int         exp_lat, e0, n, dn;

        vecs[0] = '{8'hA5, 8'h00, MODE0, 8'd4, 1'b1, 73, 8'hA5};
        vecs[1] = '{8'h3C, 8'hC3, MODE3, 8'd2, 1'b0, 37, 8'hC3};
        vecs[2] = '{8'h5A, 8'h00, MODE0, 8'd0, 1'b1, 19, 8'h5A};
        vecs[3] = '{8'h96, 8'h0F, MODE1, 8'd1, 1'b0, 19, 8'h0F};
        vecs[4] = '{8'hE7, 8'h81, MODE2, 8'd3, 1'b0, 55, 8'h81};
        vecs[5] = '{8'h01, 8'hFE, MODE0, 8'd5, 1'b0, 91, 8'hFE};

        reset = 1'b0; start = 1'b0; tx_data = 8'h00; cpol = 1'b1; cpha = 1'b1; div = 8'd3;
        hold_cs = 1'b0; loop_en = 1'b0; slave_word = 8'h00; mode_cpha = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx_data", rx_data, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sclk_latched_cpol", sclk, 0);
        check("idle_cs_n", cs_n, 1);

        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i].tx, vecs[i].sl, vecs[i].mode, vecs[i].dv, 1'b0, vecs[i].lp, 1'b0, r);
            $display("vec%0d: tx=%02h mode=%0d div=%0d lat=%0d rx=%02h mosi=%02h edges=%0d",
                     i, vecs[i].tx, vecs[i].mode, vecs[i].dv, r.lat, r.rx, r.mw, r.edges);
            check($sformatf("vec%0d_latency", i), r.lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_rx", i), r.rx, vecs[i].exp_rx);
            check($sformatf("vec%0d_mosi_bits", i), r.mw, vecs[i].tx);
            check($sformatf("vec%0d_sclk_edges", i), r.edges, 16);
            check($sformatf("vec%0d_cs_low_during", i), r.cs_hi, 0);
            check($sformatf("vec%0d_cs_n_after", i), r.cs_after, 1);
            check($sformatf("vec%0d_sclk_idle", i), r.sclk_after, vecs[i].mode[1]);
        end

        // start re-pulsed mid-transfer with different data must be ignored
        xfer(8'hA5, 8'h00, MODE0, 8'd4, 1'b0, 1'b1, 1'b1, r);
        $display("ignore: lat=%0d rx=%02h mosi=%02h", r.lat, r.rx, r.mw);
        check("ignore_latency", r.lat, 73);
        check("ignore_rx", r.rx, 8'hA5);
        check("ignore_mosi_bits", r.mw, 8'hA5);
        dn = 0;
        repeat (100) begin @(negedge clk); if (done) dn++; end
        check("ignore_single_done", dn, 0);

        // two-word frame with chip select held between words
        xfer(8'h12, 8'h00, MODE0, 8'd2, 1'b1, 1'b1, 1'b0, r);
        xfer(8'h34, 8'h00, MODE0, 8'd2, 1'b0, 1'b1, 1'b0, r2);
        $display("hold: w1 lat=%0d rx=%02h  w2 lat=%0d rx=%02h", r.lat, r.rx, r2.lat, r2.rx);
        check("hold_w1_latency", r.lat, 37);
        check("hold_w1_rx", r.rx, 8'h12);
        check("hold_w1_cs_low", r.cs_hi, 0);
        check("hold_w1_cs_at_done", r.cs_at_done, 0);
        check("hold_gap_cs", r.cs_after, 0);
        check("hold_w2_cs_at_start", r2.cs_at_start, 0);
        check("hold_w2_latency_no_lead", r2.lat, 35);
        check("hold_w2_rx", r2.rx, 8'h34);
        check("hold_w2_mosi_bits", r2.mw, 8'h34);
        check("hold_w2_cs_low", r2.cs_hi, 0);
        check("hold_w2_cs_released", r2.cs_after, 1);

        // random words against the reference model
        for (int i = 0; i < 20; i++) begin
            t_r = 8'($urandom); s_r = 8'($urandom); m_r = 2'($urandom_range(0, 3));
            dv_r = 8'($urandom_range(0, 6)); lp_r = 1'($urandom_range(0, 1));
            exp_lat = ((dv_r == 0) ? 1 : int'(dv_r)) * (2 * 8 + 2) + 1;
            exp_rx  = lp_r ? t_r : s_r;
            xfer(t_r, s_r, m_r, dv_r, 1'b0, lp_r, 1'b0, r);
            $display("rnd%0d: tx=%02h sl=%02h mode=%0d div=%0d loop=%0d lat=%0d rx=%02h",
                     i, t_r, s_r, m_r, dv_r, lp_r, r.lat, r.rx);
            check($sformatf("rnd%0d_latency", i), r.lat, exp_lat);
            check($sformatf("rnd%0d_rx", i), r.rx, exp_rx);
            check($sformatf("rnd%0d_mosi_bits", i), r.mw, t_r);
            check($sformatf("rnd%0d_sclk_edges", i), r.edges, 16);
            check($sformatf("rnd%0d_sclk_idle", i), r.sclk_after, m_r[1]);
        end

        // reset asserted part-way through a transfer
        @(negedge clk);
        slave_word = 8'h00; loop_en = 1'b1; mode_cpha = 1'b0;
        start = 1'b1; tx_data = 8'h81; cpol = 1'b0; cpha = 1'b0; div = 8'd2; hold_cs = 1'b0;
        e0 = edge_total;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (edge_total - e0 < 5 && n < 500) begin @(negedge clk); n++; end
        check("rst_mid_reach_edge5", edge_total - e0, 5);
        reset = 1'b0;
        @(negedge clk);
        $display("reset mid-xfer: cs_n=%0b busy=%0b done=%0b rx=%02h", cs_n, busy, done, rx_data);
        check("rst_mid_cs_n", cs_n, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_rx_data", rx_data, 0);
        check("rst_mid_sclk", sclk, 0);
        reset = 1'b1;
        dn = 0;
        repeat (100) begin @(negedge clk); if (done) dn++; end
        check("rst_mid_no_done", dn, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
